// File: rtl/sr_pulse_sweep_gen_if.sv
// Bus between the pulse-sweep generator and whatever drives/observes it:
// search request and parameters in, latch drives and search results out.
interface sr_pulse_sweep_gen_if #(
  parameter int PW_W    = 16,
  parameter int TRIAL_W = 12
);
  logic               start;
  logic               mode;
  logic [PW_W-1:0]    pw_init;
  logic [PW_W-1:0]    inc_init;
  logic               latch_q;
  logic               myset;
  logic               myreset;
  logic               busy;
  logic               done;
  logic [PW_W-1:0]    pw_result;
  logic [TRIAL_W-1:0] trial_count;
  logic               no_hit;
  logic               aborted;

  // Controller / latch-model side
  modport master (
    output start, mode, pw_init, inc_init, latch_q,
    input  myset, myreset, busy, done, pw_result, trial_count, no_hit, aborted
  );

  // Generator side
  modport slave (
    input  start, mode, pw_init, inc_init, latch_q,
    output myset, myreset, busy, done, pw_result, trial_count, no_hit, aborted
  );
endinterface

// File: rtl/sr_pulse_sweep_gen.sv
// Pulse-width sweep generator for one SR latch under test.
// Each trial forces the latch to a known state with an init pulse, waits,
// applies a test pulse of pw cycles on the opposite input, lets the latch
// settle and then samples its synchronised Q. An incremental search walks
// pw up by inc on failure and back by 2*inc (halving inc) on success,
// converging on the minimum width that still flips the latch.
// All counter lengths (INIT_CYC, GAP_CYC, SETTLE_CYC) must be at least 1.
module sr_pulse_sweep_gen #(
  parameter int PW_W       = 16,
  parameter int INIT_CYC   = 10,
  parameter int GAP_CYC    = 3,
  parameter int SETTLE_CYC = 150,
  parameter int TRIAL_W    = 12,
  parameter int MAX_TRIALS = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_pulse_sweep_gen_if.slave  bus
);

  // Phase counter is wider than pw so it also covers the fixed phases.
  localparam int CNT_W = PW_W + 16;
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  // Settle window includes the two synchroniser flops.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_GAP,
    S_PULSE,
    S_SETTLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   last_cnt;
  logic               cnt_end;

  logic [PW_W-1:0]    pw_r;
  logic [PW_W-1:0]    inc_r;
  logic [PW_W-1:0]    min_r;
  logic               mode_r;
  logic               hit_r;
  logic [TRIAL_W-1:0] trial_r;

  logic               myset_r;
  logic               myreset_r;
  logic               busy_r;
  logic               done_r;
  logic [PW_W-1:0]    pw_result_r;
  logic               no_hit_r;
  logic               aborted_r;

  logic               q_sync_p0;
  logic               q_sync_p1;

  logic               accept;
  logic               mode_nxt;
  logic               drive_set;
  logic               drive_rst;

  logic               success;
  logic [PW_W-1:0]    pw_upd;
  logic [PW_W-1:0]    inc_upd;
  logic [PW_W-1:0]    min_upd;
  logic               hit_nxt;
  logic [TRIAL_W-1:0] trial_inc;
  logic               abort_now;
  logic               term;

  // pw + inc, clamped to all-ones instead of wrapping.
  function automatic logic [PW_W-1:0] sat_add(input logic [PW_W-1:0] a,
                                               input logic [PW_W-1:0] b);
    logic [PW_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[PW_W])
      return '1;
    return s[PW_W-1:0];
  endfunction

  // pw - 2*inc, floored at 1 (a zero-width pulse is meaningless).
  function automatic logic [PW_W-1:0] floor_sub2(input logic [PW_W-1:0] a,
                                                  input logic [PW_W-1:0] b);
    logic [PW_W+1:0] d;
    d = {2'b00, a} - {1'b0, b, 1'b0};
    if (d[PW_W+1] || (d[PW_W:0] == '0))
      return PW_W'(1);
    return d[PW_W-1:0];
  endfunction

  // Width 0 requested by the user still means one cycle.
  function automatic logic [PW_W-1:0] at_least_one(input logic [PW_W-1:0] a);
    if (a == '0)
      return PW_W'(1);
    return a;
  endfunction

  assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign mode_nxt = accept ? bus.mode : mode_r;

  // Latch Q is asynchronous to clk; two flops before it is evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sync_p0 <= 1'b0;
      q_sync_p1 <= 1'b0;
    end else begin
      q_sync_p0 <= bus.latch_q;
      q_sync_p1 <= q_sync_p0;
    end
  end

  // Length of the phase currently being timed.
  always_comb begin
    last_cnt = '0;
    case (state)
      S_INIT:   last_cnt = INIT_LAST;
      S_GAP:    last_cnt = GAP_LAST;
      S_PULSE:  last_cnt = CNT_W'(pw_r) - CNT_W'(1);
      S_SETTLE: last_cnt = SETTLE_LAST;
      default:  last_cnt = '0;
    endcase
  end

  assign cnt_end = (cnt == last_cnt);

  // Search step evaluated at the end of each trial.
  always_comb begin
    success   = mode_r ? ~q_sync_p1 : q_sync_p1;
    trial_inc = trial_r + TRIAL_W'(1);
    pw_upd    = pw_r;
    inc_upd   = inc_r;
    min_upd   = min_r;
    hit_nxt   = hit_r;
    term      = 1'b0;
    abort_now = (trial_inc == TRIAL_W'(MAX_TRIALS));
    if (success) begin
      min_upd = (pw_r < min_r) ? pw_r : min_r;
      pw_upd  = floor_sub2(pw_r, inc_r);
      inc_upd = inc_r >> 1;
      hit_nxt = 1'b1;
      term    = (inc_upd == '0);
    end else begin
      pw_upd  = sat_add(pw_r, inc_r);
      term    = (inc_r == '0) || (pw_r == '1);
    end
    term = term || abort_now;
  end

  // Sequencer: next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept)  state_nxt = S_INIT;
      S_INIT:   if (cnt_end) state_nxt = S_GAP;
      S_GAP:    if (cnt_end) state_nxt = S_PULSE;
      S_PULSE:  if (cnt_end) state_nxt = S_SETTLE;
      S_SETTLE: if (cnt_end) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = term ? S_DONE : S_INIT;
      S_DONE:   if (accept)  state_nxt = S_INIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Drives are decoded from the upcoming state so the registered outputs
  // line up exactly with the INIT and PULSE phases.
  always_comb begin
    drive_set = ((state_nxt == S_PULSE) && !mode_nxt) ||
                ((state_nxt == S_INIT)  &&  mode_nxt);
    drive_rst = ((state_nxt == S_PULSE) &&  mode_nxt) ||
                ((state_nxt == S_INIT)  && !mode_nxt);
  end

  // State register and phase counter (restarts on every phase change).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if ((state == S_INIT) || (state == S_GAP) ||
               (state == S_PULSE) || (state == S_SETTLE))
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Search registers: loaded on an accepted start, stepped in EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw_r        <= '0;
      inc_r       <= '0;
      min_r       <= '1;
      mode_r      <= 1'b0;
      hit_r       <= 1'b0;
      trial_r     <= '0;
      pw_result_r <= '1;
      no_hit_r    <= 1'b0;
      aborted_r   <= 1'b0;
    end else if (accept) begin
      pw_r      <= at_least_one(bus.pw_init);
      inc_r     <= bus.inc_init;
      mode_r    <= bus.mode;
      min_r     <= '1;
      hit_r     <= 1'b0;
      trial_r   <= '0;
      no_hit_r  <= 1'b0;
      aborted_r <= 1'b0;
    end else if (state == S_EVAL) begin
      pw_r    <= pw_upd;
      inc_r   <= inc_upd;
      min_r   <= min_upd;
      hit_r   <= hit_nxt;
      trial_r <= trial_inc;
      if (term) begin
        pw_result_r <= min_upd;
        no_hit_r    <= ~hit_nxt;
        aborted_r   <= abort_now;
      end
    end
  end

  // Registered latch drives and status levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      myset_r   <= 1'b0;
      myreset_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      myset_r   <= drive_set;
      myreset_r <= drive_rst;
      busy_r    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_r    <= (state_nxt == S_DONE);
    end
  end

  assign bus.myset       = myset_r;
  assign bus.myreset     = myreset_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.pw_result   = pw_result_r;
  assign bus.trial_count = trial_r;
  assign bus.no_hit      = no_hit_r;
  assign bus.aborted     = aborted_r;

endmodule

// File: tb/tb_sr_pulse_sweep_gen.sv
// Directed bench for sr_pulse_sweep_gen: behavioural latch models with
// programmable set/reset thresholds, pulse-width recording, and one task
// per scenario with hand-computed expectations.
module tb_sr_pulse_sweep_gen;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sr_pulse_sweep_gen_if #(.PW_W(16), .TRIAL_W(12)) bus_a ();
  sr_pulse_sweep_gen_if #(.PW_W(8),  .TRIAL_W(12)) bus_b ();

  sr_pulse_sweep_gen #(
    .PW_W(16), .INIT_CYC(10), .GAP_CYC(3), .SETTLE_CYC(150),
    .TRIAL_W(12), .MAX_TRIALS(4095)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  sr_pulse_sweep_gen #(
    .PW_W(8), .INIT_CYC(10), .GAP_CYC(3), .SETTLE_CYC(20),
    .TRIAL_W(12), .MAX_TRIALS(3)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latch model A: Q sets once set has been held set_thr cycles, clears once
  // reset has been held rst_thr cycles. Pulse widths are recorded.
  int a_set_thr;
  int a_rst_thr;
  int a_srun;
  int a_rrun;
  int a_overlap;
  int a_set_w[$];
  int a_rst_w[$];

  always @(posedge clk) begin
    a_srun <= bus_a.myset   ? a_srun + 1 : 0;
    a_rrun <= bus_a.myreset ? a_rrun + 1 : 0;
    if (!bus_a.myset && a_srun > 0)   a_set_w.push_back(a_srun);
    if (!bus_a.myreset && a_rrun > 0) a_rst_w.push_back(a_rrun);
    if (bus_a.myset && bus_a.myreset) a_overlap <= a_overlap + 1;
    if (rst)
      bus_a.latch_q <= 1'b0;
    else if (bus_a.myset && (a_srun + 1 >= a_set_thr))
      bus_a.latch_q <= 1'b1;
    else if (bus_a.myreset && (a_rrun + 1 >= a_rst_thr))
      bus_a.latch_q <= 1'b0;
  end

  // Latch model B never flips; only its set pulse widths are recorded.
  int b_srun;
  int b_set_w[$];

  always @(posedge clk) begin
    b_srun <= bus_b.myset ? b_srun + 1 : 0;
    if (!bus_b.myset && b_srun > 0) b_set_w.push_back(b_srun);
    bus_b.latch_q <= 1'b0;
  end

  task automatic start_a(input logic m, input logic [15:0] pw, input logic [15:0] inc);
    @(negedge clk);
    bus_a.mode     = m;
    bus_a.pw_init  = pw;
    bus_a.inc_init = inc;
    bus_a.start    = 1'b1;
    @(negedge clk);
    bus_a.start    = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] pw, input logic [7:0] inc);
    @(negedge clk);
    bus_b.mode     = 1'b0;
    bus_b.pw_init  = pw;
    bus_b.inc_init = inc;
    bus_b.start    = 1'b1;
    @(negedge clk);
    bus_b.start    = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_a.done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_done_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_b.done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus_a.myset !== 1'b0) begin bad++; $display("FAIL reset_myset got=%b want=0", bus_a.myset); end
    total++; if (bus_a.myreset !== 1'b0) begin bad++; $display("FAIL reset_myreset got=%b want=0", bus_a.myreset); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_a.done); end
    total++; if (bus_a.pw_result !== 16'hFFFF) begin bad++; $display("FAIL reset_pw_result got=%h want=ffff", bus_a.pw_result); end
    total++; if (bus_a.trial_count !== 12'd0) begin bad++; $display("FAIL reset_trials got=%0d want=0", bus_a.trial_count); end
    total++; if ({bus_a.no_hit, bus_a.aborted} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {bus_a.no_hit, bus_a.aborted}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set_sweep();
    int exp_w[12] = '{4, 8, 12, 16, 8, 10, 12, 14, 10, 11, 12, 13};
    bit ok;
    a_set_thr = 13;
    a_rst_thr = 1;
    a_set_w.delete();
    a_overlap = 0;
    start_a(1'b0, 16'd4, 16'd4);
    total++; if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin bad++; $display("FAIL sweep_busy_rise got=%b%b want=10", bus_a.busy, bus_a.done); end
    repeat (50) @(negedge clk);
    // A start while busy must be ignored.
    start_a(1'b1, 16'd99, 16'd0);
    bus_a.mode = 1'b0;
    wait_done_a(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sweep_timeout got=not_done want=done"); end
    total++; if (bus_a.pw_result !== 16'd13) begin bad++; $display("FAIL sweep_pw_result got=%0d want=13", bus_a.pw_result); end
    total++; if (bus_a.trial_count !== 12'd12) begin bad++; $display("FAIL sweep_trials got=%0d want=12", bus_a.trial_count); end
    total++; if ({bus_a.no_hit, bus_a.aborted, bus_a.busy} !== 3'b000) begin bad++; $display("FAIL sweep_flags got=%b want=000", {bus_a.no_hit, bus_a.aborted, bus_a.busy}); end
    total++; if (a_set_w.size() != 12) begin bad++; $display("FAIL sweep_pulse_count got=%0d want=12", a_set_w.size()); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= a_set_w.size() || a_set_w[i] != exp_w[i]) begin
        bad++;
        $display("FAIL sweep_width[%0d] got=%0d want=%0d", i, (i < a_set_w.size()) ? a_set_w[i] : -1, exp_w[i]);
      end
    end
    total++; if (a_overlap != 0) begin bad++; $display("FAIL sweep_overlap got=%0d want=0", a_overlap); end
  endtask

  task automatic test_single_trial();
    bit ok;
    a_set_w.delete();
    total++; if (bus_a.done !== 1'b1) begin bad++; $display("FAIL single_pre_done got=%b want=1", bus_a.done); end
    start_a(1'b0, 16'd20, 16'd0);
    total++; if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b1) begin bad++; $display("FAIL single_restart got=%b%b want=01", bus_a.done, bus_a.busy); end
    wait_done_a(5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=not_done want=done"); end
    total++; if (bus_a.pw_result !== 16'd20) begin bad++; $display("FAIL single_pw_result got=%0d want=20", bus_a.pw_result); end
    total++; if (bus_a.trial_count !== 12'd1) begin bad++; $display("FAIL single_trials got=%0d want=1", bus_a.trial_count); end
    total++; if (a_set_w.size() != 1 || a_set_w[0] != 20) begin bad++; $display("FAIL single_width got=%0d want=20", (a_set_w.size() > 0) ? a_set_w[0] : -1); end
  endtask

  task automatic test_reset_sweep();
    int exp_w[9] = '{1, 3, 5, 7, 3, 4, 5, 6, 7};
    bit ok;
    a_set_thr = 1;
    a_rst_thr = 7;
    a_set_w.delete();
    a_rst_w.delete();
    a_overlap = 0;
    start_a(1'b1, 16'd1, 16'd2);
    wait_done_a(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rsweep_timeout got=not_done want=done"); end
    total++; if (bus_a.pw_result !== 16'd7) begin bad++; $display("FAIL rsweep_pw_result got=%0d want=7", bus_a.pw_result); end
    total++; if (bus_a.trial_count !== 12'd9) begin bad++; $display("FAIL rsweep_trials got=%0d want=9", bus_a.trial_count); end
    total++; if (a_rst_w.size() != 9) begin bad++; $display("FAIL rsweep_pulse_count got=%0d want=9", a_rst_w.size()); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= a_rst_w.size() || a_rst_w[i] != exp_w[i]) begin
        bad++;
        $display("FAIL rsweep_width[%0d] got=%0d want=%0d", i, (i < a_rst_w.size()) ? a_rst_w[i] : -1, exp_w[i]);
      end
    end
    total++; if (a_set_w.size() != 9 || a_set_w[0] != 10) begin bad++; $display("FAIL rsweep_init_pulses got=%0d want=9", a_set_w.size()); end
    total++; if (a_overlap != 0) begin bad++; $display("FAIL rsweep_overlap got=%0d want=0", a_overlap); end
  endtask

  task automatic test_reset_mid_pulse();
    bit ok;
    bit seen;
    a_set_thr = 13;
    a_rst_thr = 1;
    start_a(1'b0, 16'd20, 16'd0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.myset) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_pulse_seen got=0 want=1"); end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (bus_a.myset !== 1'b0) begin bad++; $display("FAIL midrst_myset got=%b want=0", bus_a.myset); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.trial_count !== 12'd0) begin bad++; $display("FAIL midrst_trials got=%0d want=0", bus_a.trial_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b%b want=00", bus_a.busy, bus_a.done); end
    start_a(1'b0, 16'd20, 16'd0);
    wait_done_a(5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_timeout got=not_done want=done"); end
    total++; if (bus_a.trial_count !== 12'd1) begin bad++; $display("FAIL midrst_fresh_trials got=%0d want=1", bus_a.trial_count); end
    total++; if (bus_a.pw_result !== 16'd20) begin bad++; $display("FAIL midrst_fresh_pw got=%0d want=20", bus_a.pw_result); end
  endtask

  task automatic test_saturate();
    bit ok;
    b_set_w.delete();
    start_b(8'hF8, 8'd8);
    wait_done_b(5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=not_done want=done"); end
    total++; if (bus_b.no_hit !== 1'b1) begin bad++; $display("FAIL sat_no_hit got=%b want=1", bus_b.no_hit); end
    total++; if (bus_b.pw_result !== 8'hFF) begin bad++; $display("FAIL sat_pw_result got=%h want=ff", bus_b.pw_result); end
    total++; if (bus_b.trial_count !== 12'd2) begin bad++; $display("FAIL sat_trials got=%0d want=2", bus_b.trial_count); end
    total++; if (bus_b.aborted !== 1'b0) begin bad++; $display("FAIL sat_aborted got=%b want=0", bus_b.aborted); end
    total++; if (b_set_w.size() != 2 || b_set_w[1] != 255) begin bad++; $display("FAIL sat_last_width got=%0d want=255", (b_set_w.size() > 1) ? b_set_w[1] : -1); end
  endtask

  task automatic test_abort();
    bit ok;
    start_b(8'd1, 8'd1);
    wait_done_b(5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_timeout got=not_done want=done"); end
    total++; if (bus_b.aborted !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b want=1", bus_b.aborted); end
    total++; if (bus_b.trial_count !== 12'd3) begin bad++; $display("FAIL abort_trials got=%0d want=3", bus_b.trial_count); end
    total++; if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0) begin bad++; $display("FAIL abort_done got=%b%b want=10", bus_b.done, bus_b.busy); end
    total++; if (bus_b.no_hit !== 1'b1) begin bad++; $display("FAIL abort_no_hit got=%b want=1", bus_b.no_hit); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    a_set_thr = 13;
    a_rst_thr = 1;
    a_overlap = 0;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.pw_init = '0; bus_a.inc_init = '0;
    bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.pw_init = '0; bus_b.inc_init = '0;
    test_reset();
    test_set_sweep();
    test_single_trial();
    test_reset_sweep();
    test_reset_mid_pulse();
    test_saturate();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_pulse_sweep_gen.md
Name: sr_pulse_sweep_gen

Overview:
- Synthesisable, clocked successor to the hand-written SR-latch pulse-width stimulus.
- Drives the set and reset inputs of one latch under test. Each trial is an init pulse, then a test pulse of programmable width in clock cycles.
- After each trial it samples the latch output through a synchroniser and runs an incremental search for the minimum test-pulse width that still flips the latch.
- Generalised over counter width, timing and mode (set-sweep or reset-sweep); reports the threshold width, the trial count and status flags.

Parameters:
PW_W, 16, width of the pulse-width, increment and result registers
INIT_CYC, 10, length in cycles of the init pulse that forces the latch to a known state
GAP_CYC, 3, idle cycles between the end of the init pulse and the start of the test pulse
SETTLE_CYC, 150, idle cycles after the test pulse before sampling, excluding synchroniser latency
TRIAL_W, 12, width of the trial counter
MAX_TRIALS, 4095, trial limit; reaching it aborts the search

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a search; sampled only in IDLE or DONE
mode  in  1  0 = sweep the set pulse (init with reset, success when q=1); 1 = sweep the reset pulse (init with set, success when q=0); captured on start
pw_init  in  PW_W  first test-pulse width in cycles; captured on start; value 0 is treated as 1
inc_init  in  PW_W  initial search step; captured on start; value 0 means a single trial
latch_q  in  1  asynchronous latch Q output, passed through an internal 2-flop synchroniser
myset  out  1  latch set drive
myreset  out  1  latch reset drive
busy  out  1  high from the cycle after start until the search terminates
done  out  1  level; high in DONE until the next accepted start
pw_result  out  PW_W  smallest test width that produced success; all-ones if none did
trial_count  out  TRIAL_W  number of trials completed
no_hit  out  1  set at termination if no trial succeeded
aborted  out  1  set at termination if MAX_TRIALS was reached

Behaviour:
- Reset: all outputs 0 except pw_result, which resets to all-ones; state is IDLE; synchroniser flops are 0. Reset asserted mid-trial drops myset and myreset asynchronously in the same instant.
- Capture on start: in IDLE/DONE, start=1 loads pw=max(pw_init,1), inc=inc_init, mode, min=all-ones, trial_count=0, and clears the status flags. done falls and busy rises on the next cycle.
- States and the drive in each:
  - INIT: for INIT_CYC cycles, drive myreset (mode 0) or myset (mode 1).
  - GAP: GAP_CYC cycles, both drives low.
  - PULSE: exactly pw cycles; drive myset (mode 0) or myreset (mode 1).
  - SETTLE: SETTLE_CYC+2 cycles, both drives low.
  - EVAL: one cycle.
  - Then INIT again, or DONE.
- Drive rules: myset and myreset are registered outputs and are never high in the same cycle.
- Trial duration: INIT_CYC + GAP_CYC + pw + SETTLE_CYC + 3 cycles.
- Success test in EVAL: synchronised q equals 1 in mode 0, or 0 in mode 1.
- EVAL updates:
  - trial_count increments in every EVAL.
  - On success: min=min(min,pw); pw=pw-2*inc, floored at 1; inc=inc>>1.
  - On fail: pw=pw+inc, saturating at all-ones.
- Termination, checked after the update:
  - inc==0 after a success;
  - a fail with inc==0;
  - a fail while pw is already all-ones;
  - trial_count reaching MAX_TRIALS, which sets aborted.
- At termination: pw_result=min; no_hit=(min==all-ones with no recorded success, tracked by an internal flag); go to DONE.
- start while busy is ignored. A start in DONE restarts the search.

Test Plan:
- Model the latch so it sets when the set pulse is at least 13 cycles. mode=0, pw_init=4, inc_init=4 -> trial widths 4,8,12,16,8,10,12,14,10,11,12,13; done with pw_result=13, trial_count=12, no_hit=0.
- Same model, pw_init=20, inc_init=0 -> exactly one trial of 20 cycles; pw_result=20, trial_count=1.
- Threshold set unreachable (latch never flips), pw_init=0xFFF0, inc_init=8 -> pw saturates at 0xFFFF; termination with no_hit=1 and pw_result=0xFFFF.
- mode=1 with the model: the reset pulse must be at least 7 cycles. pw_init=1, inc_init=2 -> myset init pulses and myreset test pulses; pw_result=7; myset and myreset are never both high.
- Assert rst during PULSE -> myset=0 immediately, busy=0, state IDLE. A following start runs a fresh search with trial_count starting from 0.
- MAX_TRIALS=3, with the latch never flipping -> aborted=1, trial_count=3, done=1.
